// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM data-memory port arbiter.
package mem_arb_pkg;

  // Originator of a bus transaction, tracked in issue order.
  typedef enum logic {REQ_IF, REQ_MEM} req_id_t;

  // ARB_HOLD freezes the grant while the bus has not yet accepted it.
  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for transactions in flight on the bus.
module arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  req_id_t          push_id,
  input  logic             pop,
  output req_id_t          head_id,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_id_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_id = mem[rd_ptr];

  // Pointer, count and storage update; caller never pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= REQ_IF;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and the
// memory stage, tracks in-flight transactions and routes responses back.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_wstrb,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  i_addr_ok,
  output logic                  d_addr_ok,
  output logic                  i_data_ok,
  output logic                  d_data_ok,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_wstrb,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  protocol_err
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state_q, state_d;
  req_id_t          grant_q, grant_d;
  req_id_t          sel;
  req_id_t          head_id;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_q;
  logic             sel_req;
  logic             accept;
  logic             rsp_valid;

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .push_id (sel),
    .pop     (rsp_valid),
    .head_id (head_id),
    .count   (count)
  );

  // Grant selection, request forwarding, response routing and next state.
  // Bus fields are gated by bus_req so an idle port presents all zeros.
  always_comb begin
    sel = grant_q;
    if (state_q == ARB_IDLE) begin
      if (i_req && (starve_q == STV_W'(STARVE_LIMIT))) sel = REQ_IF;
      else if (d_req)                                 sel = REQ_MEM;
      else                                            sel = REQ_IF;
    end

    sel_req = (sel == REQ_MEM) ? d_req : i_req;
    bus_req = sel_req && (count < CNT_W'(MAX_OUTSTANDING));
    accept  = bus_req && bus_addr_ok;

    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wstrb = '0;
    bus_wdata = '0;
    if (bus_req) begin
      if (sel == REQ_MEM) begin
        bus_wr    = d_wr;
        bus_addr  = d_addr;
        bus_wstrb = d_wstrb;
        bus_wdata = d_wdata;
      end else begin
        bus_addr  = i_addr;
      end
    end

    i_addr_ok = accept && (sel == REQ_IF);
    d_addr_ok = accept && (sel == REQ_MEM);

    rsp_valid = bus_data_ok && (count != '0);
    i_data_ok = rsp_valid && (head_id == REQ_IF);
    d_data_ok = rsp_valid && (head_id == REQ_MEM);
    rdata     = bus_rdata;

    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (bus_req && !bus_addr_ok) begin
          state_d = ARB_HOLD;
          grant_d = sel;
        end
      end
      ARB_HOLD: begin
        if (accept) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbitration state and frozen grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= REQ_IF;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Starve counter: counts data grants taken while fetch waits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (accept) begin
      if (sel == REQ_IF) begin
        starve_q <= '0;
      end else if (i_req && (starve_q != STV_W'(STARVE_LIMIT))) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      protocol_err <= 1'b0;
    end else if (bus_data_ok && (count == '0)) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [31:0] i_addr, d_addr;
  logic [3:0]  d_wstrb;
  logic [31:0] d_wdata;
  logic        i_addr_ok, d_addr_ok, i_data_ok, d_data_ok;
  logic [31:0] rdata;
  logic        bus_req, bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        protocol_err;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2),
    .STARVE_LIMIT    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .d_req        (d_req),
    .d_wr         (d_wr),
    .i_addr       (i_addr),
    .d_addr       (d_addr),
    .d_wstrb      (d_wstrb),
    .d_wdata      (d_wdata),
    .i_addr_ok    (i_addr_ok),
    .d_addr_ok    (d_addr_ok),
    .i_data_ok    (i_data_ok),
    .d_data_ok    (d_data_ok),
    .rdata        (rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .protocol_err (protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_in();
    i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 32'h40; d_addr = 32'h80; d_wstrb = 4'h0; d_wdata = 32'h0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic chk_zero(input string tag);
    settle();
    chk({tag, "_i_addr_ok"}, i_addr_ok, 0);
    chk({tag, "_d_addr_ok"}, d_addr_ok, 0);
    chk({tag, "_i_data_ok"}, i_data_ok, 0);
    chk({tag, "_d_data_ok"}, d_data_ok, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_bus_wr"}, bus_wr, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wstrb"}, {28'h0, bus_wstrb}, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_protocol_err"}, protocol_err, 0);
  endtask

  initial begin
    logic exp_fetch;

    // Reset state
    rst_n = 0;
    idle_in();
    tick();
    do_reset();
    chk_zero("reset");
    tick();

    // Starvation: data accepted on cycles 0-3, fetch forced on 4, data on 5
    i_req = 1; i_addr = 32'h100;
    d_req = 1; d_wr = 1; d_addr = 32'h2000; d_wstrb = 4'hF; d_wdata = 32'h11;
    bus_addr_ok = 1;
    for (int k = 0; k < 6; k++) begin
      bus_data_ok = (k != 0);
      bus_rdata   = 32'hA0 + 32'(k);
      settle();
      exp_fetch = (k == 4);
      chk($sformatf("starve%0d_bus_req", k), bus_req, 1);
      chk($sformatf("starve%0d_bus_addr", k), bus_addr, exp_fetch ? 32'h100 : 32'h2000);
      chk($sformatf("starve%0d_bus_wr", k), bus_wr, exp_fetch ? 0 : 1);
      chk($sformatf("starve%0d_bus_wstrb", k), {28'h0, bus_wstrb}, exp_fetch ? 0 : 32'hF);
      chk($sformatf("starve%0d_bus_wdata", k), bus_wdata, exp_fetch ? 0 : 32'h11);
      chk($sformatf("starve%0d_i_addr_ok", k), i_addr_ok, exp_fetch ? 1 : 0);
      chk($sformatf("starve%0d_d_addr_ok", k), d_addr_ok, exp_fetch ? 0 : 1);
      chk($sformatf("starve%0d_i_data_ok", k), i_data_ok, (k == 5) ? 1 : 0);
      chk($sformatf("starve%0d_d_data_ok", k), d_data_ok, (k >= 1 && k != 5) ? 1 : 0);
      chk($sformatf("starve%0d_rdata", k), rdata, 32'hA0 + 32'(k));
      tick();
    end
    i_req = 0; d_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    settle();
    chk("starve_drain_d_data_ok", d_data_ok, 1);
    chk("starve_drain_bus_req", bus_req, 0);
    tick();

    // Hold: data at 0x1000 stalled 3 cycles, fetch raised in cycle 1
    do_reset();
    d_req = 1; d_wr = 0; d_addr = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin i_req = 1; i_addr = 32'h300; end
      bus_addr_ok = (k == 3);
      settle();
      chk($sformatf("hold%0d_bus_addr", k), bus_addr, 32'h1000);
      chk($sformatf("hold%0d_d_addr_ok", k), d_addr_ok, (k == 3) ? 1 : 0);
      chk($sformatf("hold%0d_i_addr_ok", k), i_addr_ok, 0);
      tick();
    end
    // Fetch now granted but stalled; a new data request must not preempt it
    d_req = 0; bus_addr_ok = 0;
    settle();
    chk("hold_fetch_bus_addr", bus_addr, 32'h300);
    tick();
    d_req = 1; d_addr = 32'h1004;
    settle();
    chk("hold_frozen_bus_addr", bus_addr, 32'h300);
    chk("hold_frozen_d_addr_ok", d_addr_ok, 0);
    tick();
    bus_addr_ok = 1;
    settle();
    chk("hold_fetch_accept", i_addr_ok, 1);
    chk("hold_fetch_accept_addr", bus_addr, 32'h300);
    tick();

    // Full: fetch then data accepted, third request blocked
    do_reset();
    i_req = 1; i_addr = 32'h400; bus_addr_ok = 1;
    settle();
    chk("full_fetch_accept", i_addr_ok, 1);
    tick();
    i_req = 0; d_req = 1; d_addr = 32'h500;
    settle();
    chk("full_data_accept", d_addr_ok, 1);
    tick();
    d_addr = 32'h504;
    settle();
    chk("full_blocked_bus_req", bus_req, 0);
    chk("full_blocked_d_addr_ok", d_addr_ok, 0);
    tick();
    bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
    settle();
    chk("full_rsp_i_data_ok", i_data_ok, 1);
    chk("full_rsp_d_data_ok", d_data_ok, 0);
    chk("full_rsp_rdata", rdata, 32'hDEADBEEF);
    chk("full_rsp_bus_req", bus_req, 0);
    tick();
    bus_data_ok = 0;
    settle();
    chk("full_issue_bus_req", bus_req, 1);
    chk("full_issue_bus_addr", bus_addr, 32'h504);
    chk("full_issue_d_addr_ok", d_addr_ok, 1);
    tick();
    d_req = 0; bus_data_ok = 1; bus_rdata = 32'h55;
    settle();
    chk("full_rsp2_d_data_ok", d_data_ok, 1);
    tick();
    settle();
    chk("full_rsp3_d_data_ok", d_data_ok, 1);
    tick();

    // Simultaneous accept and response with one outstanding
    bus_data_ok = 0; i_req = 1; i_addr = 32'h600; bus_addr_ok = 1;
    settle();
    chk("sim_fetch_accept", i_addr_ok, 1);
    tick();
    i_req = 0; d_req = 1; d_wr = 1; d_addr = 32'h700; bus_data_ok = 1;
    settle();
    chk("sim_i_data_ok", i_data_ok, 1);
    chk("sim_d_data_ok", d_data_ok, 0);
    chk("sim_d_addr_ok", d_addr_ok, 1);
    tick();
    d_req = 0; bus_addr_ok = 0;
    settle();
    chk("sim_next_d_data_ok", d_data_ok, 1);
    chk("sim_next_i_data_ok", i_data_ok, 0);
    tick();

    // Stray response with nothing outstanding
    settle();
    chk("stray_i_data_ok", i_data_ok, 0);
    chk("stray_d_data_ok", d_data_ok, 0);
    chk("stray_err_before", protocol_err, 0);
    tick();
    bus_data_ok = 0;
    settle();
    chk("stray_err_set", protocol_err, 1);
    tick();
    tick();
    settle();
    chk("stray_err_sticky", protocol_err, 1);
    tick();

    // Reset with two outstanding, then a stray response
    do_reset();
    chk_zero("rst_clear");
    tick();
    i_req = 1; i_addr = 32'h800; bus_addr_ok = 1;
    tick();
    i_req = 0; d_req = 1; d_addr = 32'h900;
    settle();
    chk("rst2_d_addr_ok", d_addr_ok, 1);
    tick();
    do_reset();
    chk_zero("rst_outstanding");
    tick();
    bus_data_ok = 1;
    settle();
    chk("rst_stray_i_data_ok", i_data_ok, 0);
    chk("rst_stray_d_data_ok", d_data_ok, 0);
    tick();
    bus_data_ok = 0;
    settle();
    chk("rst_stray_err", protocol_err, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
